rs_ff_pulse_gen: RTL and testbench
==================================

Name: rs_ff_pulse_gen

Overview:
Upstream front end for the synchronous RS-FF stage. It takes two raw, bouncy push-button levels (set, reset), then synchronises and debounces them. It converts each clean press into a single-cycle S or R strobe plus a coincident gate pulse G, which the RS-FF consumes as S, R and Cp. It guarantees the forbidden S=R=1 combination is never presented downstream.

Parameters:
DEB_CNT, 4, consecutive cycles a synchronised input must differ from its debounced level before the debounced level updates (legal 2..255).
PRIORITY, 0, simultaneous-press policy: 0 = reject both and pulse conflict; 1 = reset wins.

Ports:
Cp  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
set_btn  input  1  raw set button level, asynchronous to Cp.
rst_btn  input  1  raw reset button level, asynchronous to Cp.
S_out  output  1  set strobe to RS-FF S input.
R_out  output  1  reset strobe to RS-FF R input.
G  output  1  gate strobe to RS-FF Cp input; high exactly when S_out or R_out is high.
conflict  output  1  one-cycle pulse on a rejected simultaneous press (PRIORITY=0 only).
busy  output  1  high while in HOLD (a press has been accepted and not yet released).

Behaviour:
- Reset (async, rst=1): the following all clear to 0 immediately and stay 0 while rst=1:
  - sync flops, debounced levels, debounce counters, edge registers;
  - S_out, R_out, G, conflict, busy;
  - FSM goes to IDLE.
- Synchroniser: two-flop chain per button (s1, s2); no logic between the flops.
- Debounce, per channel:
  - Counter width ceil(log2(DEB_CNT)).
  - If s2 == deb, the counter clears.
  - Otherwise the counter increments. When the counter == DEB_CNT-1 and s2 still != deb, deb <= s2 and the counter clears on the same edge.
  - Glitches shorter than DEB_CNT cycles never reach deb.
- Edge detect: rise = deb & ~deb_d, where deb_d is deb delayed one cycle.
- Latency: a button change stable from before edge 1 gives a deb change at edge 2+DEB_CNT and an output strobe at edge 3+DEB_CNT (edge 7 for DEB_CNT=4).
- FSM has two states, IDLE and HOLD.
- IDLE:
  - set_rise only -> S_out=G=1 for one cycle; go to HOLD.
  - rst_rise only -> R_out=G=1 for one cycle; go to HOLD.
  - Both rises on the same cycle, PRIORITY=0 -> no S/R/G, conflict=1 for one cycle; go to HOLD.
  - Both rises on the same cycle, PRIORITY=1 -> R_out=G=1; go to HOLD.
  - No rise -> stay in IDLE.
- HOLD:
  - busy=1.
  - All further rises are ignored; no strobes are issued.
  - Return to IDLE on the cycle both debounced levels are 0.
- All outputs are registered; S_out and R_out are never high together.
- Strobe width is exactly one Cp cycle regardless of how long the press lasts.
- Reset mid-press: outputs drop immediately. After rst releases, a still-held button is treated as a fresh press and produces a strobe 3+DEB_CNT edges later.
- Reset asserted on the same edge a strobe would issue: reset wins and no strobe appears.

Test Plan:
1. DEB_CNT=4. set_btn 0->1 before edge 1, held for 20 cycles -> S_out=G=1 only in the cycle after edge 7; R_out=0; busy=1 from edge 7 until 6 edges after release, then 0.
2. rst_btn pulses high for 3 cycles (shorter than DEB_CNT) -> no strobe, busy stays 0.
3. set_btn bounces 1,0,1,0 each cycle, then stays high -> exactly one S_out pulse, 7 edges after the final stable rise.
4. set_btn and rst_btn rise on the same cycle, PRIORITY=0 -> conflict=1 for one cycle, G never high. Repeat with PRIORITY=1 -> R_out=G=1 once, S_out stays 0.
5. Hold set_btn, then press rst_btn while busy=1 -> no R_out. Release both, press rst_btn alone -> R_out pulse.
6. Assert rst mid-HOLD with set_btn held -> all outputs 0 asynchronously. Deassert rst -> S_out pulse 7 edges later.

Source files
------------

// File: rtl/rs_ff_pulse_gen.sv
// Push-button front end for the synchronous RS-FF: synchronises and debounces two
// raw buttons and turns each clean press into a single-cycle S/R strobe with gate G.
module rs_ff_pulse_gen #(
    parameter int DEB_CNT  = 4,
    parameter bit PRIORITY = 1'b0
) (
    input  logic Cp,
    input  logic rst,
    input  logic set_btn,
    input  logic rst_btn,
    output logic S_out,
    output logic R_out,
    output logic G,
    output logic conflict,
    output logic busy
);

    localparam int CNT_W = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    // Channel 0 is the set button, channel 1 the reset button.
    logic [1:0]       btn;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       deb;
    logic [1:0]       deb_d;
    logic [1:0]       rise;
    logic [CNT_W-1:0] cnt [2];

    state_t state;
    state_t state_nxt;
    logic   s_nxt;
    logic   r_nxt;
    logic   c_nxt;

    assign btn = {rst_btn, set_btn};

    // Stage: two-flop synchroniser
    always_ff @(posedge Cp or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Stage: debounce and edge register
    always_ff @(posedge Cp or posedge rst) begin
        if (rst) begin
            deb    <= '0;
            deb_d  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = deb & ~deb_d;

    // Stage: press FSM, decides which strobe (if any) to issue
    always_comb begin
        state_nxt = state;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        c_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (rise == 2'b11) begin
                    state_nxt = HOLD;
                    if (PRIORITY) r_nxt = 1'b1;
                    else          c_nxt = 1'b1;
                end else if (rise[0]) begin
                    state_nxt = HOLD;
                    s_nxt     = 1'b1;
                end else if (rise[1]) begin
                    state_nxt = HOLD;
                    r_nxt     = 1'b1;
                end
            end
            HOLD: begin
                // Only a full release of both buttons re-arms the generator.
                if (deb == 2'b00) state_nxt = IDLE;
            end
        endcase
    end

    // Stage: registered outputs
    always_ff @(posedge Cp or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            S_out    <= 1'b0;
            R_out    <= 1'b0;
            G        <= 1'b0;
            conflict <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            S_out    <= s_nxt;
            R_out    <= r_nxt;
            G        <= s_nxt | r_nxt;
            conflict <= c_nxt;
            busy     <= (state_nxt == HOLD);
        end
    end

endmodule

// File: tb/tb_rs_ff_pulse_gen.sv
// Bench for rs_ff_pulse_gen: both PRIORITY settings side by side, a hand-derived
// vector table, corner-case sequences and random presses against a window-based model.
module tb_rs_ff_pulse_gen;

    localparam int DEB_CNT = 4;

    logic Cp = 1'b0;
    logic rst;
    logic set_btn;
    logic rst_btn;
    logic S0, R0, G0, c0, b0;
    logic S1, R1, G1, c1, b1;
    logic [4:0] out0;
    logic [4:0] out1;

    int n_checks = 0;
    int n_err    = 0;

    rs_ff_pulse_gen #(.DEB_CNT(DEB_CNT), .PRIORITY(1'b0)) dut0 (
        .Cp(Cp), .rst(rst), .set_btn(set_btn), .rst_btn(rst_btn),
        .S_out(S0), .R_out(R0), .G(G0), .conflict(c0), .busy(b0)
    );

    rs_ff_pulse_gen #(.DEB_CNT(DEB_CNT), .PRIORITY(1'b1)) dut1 (
        .Cp(Cp), .rst(rst), .set_btn(set_btn), .rst_btn(rst_btn),
        .S_out(S1), .R_out(R1), .G(G1), .conflict(c1), .busy(b1)
    );

    always #5 Cp = ~Cp;

    // Output vector layout: {S_out, R_out, G, conflict, busy}
    assign out0 = {S0, R0, G0, c0, b0};
    assign out1 = {S1, R1, G1, c1, b1};

    // Reference model: the debounced level flips once the last DEB_CNT synchronised
    // samples since the previous flip (or reset) all disagree with it.
    logic [1:0] m_s1, m_s2, m_deb, m_deb_d;
    logic       m_hold [2];
    logic [4:0] m_exp  [2];
    logic [1:0] hist   [$];
    int         base   [2];

    function automatic void model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_deb = 2'b00; m_deb_d = 2'b00;
        hist.delete();
        for (int p = 0; p < 2; p++) begin
            base[p]   = 0;
            m_hold[p] = 1'b0;
            m_exp[p]  = 5'b00000;
        end
    endfunction

    function automatic void model_edge();
        logic [1:0] samp, nd, rise;
        logic [4:0] o;
        int         n;
        bit         all_diff;
        samp = m_s2;
        nd   = m_deb;
        rise = m_deb & ~m_deb_d;
        hist.push_back(samp);
        n = hist.size();
        for (int ch = 0; ch < 2; ch++) begin
            if (n - base[ch] >= DEB_CNT) begin
                all_diff = 1'b1;
                for (int k = n - DEB_CNT; k < n; k++)
                    if (hist[k][ch] == m_deb[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    nd[ch]   = samp[ch];
                    base[ch] = n;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            o = 5'b00000;
            if (!m_hold[p]) begin
                if (rise == 2'b11) begin
                    m_hold[p] = 1'b1;
                    o = (p == 1) ? 5'b01100 : 5'b00010;
                end else if (rise[0]) begin
                    m_hold[p] = 1'b1;
                    o = 5'b10100;
                end else if (rise[1]) begin
                    m_hold[p] = 1'b1;
                    o = 5'b01100;
                end
            end else if (m_deb == 2'b00) begin
                m_hold[p] = 1'b0;
            end
            o[0] = m_hold[p];
            m_exp[p] = o;
        end
        m_deb_d = m_deb;
        m_deb   = nd;
        m_s2    = m_s1;
        m_s1    = {rst_btn, set_btn};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Cp);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check("model_p0", {27'd0, out0}, {27'd0, m_exp[0]});
        check("model_p1", {27'd0, out1}, {27'd0, m_exp[1]});
    endtask

    typedef struct {
        logic       set_b;
        logic       rst_b;
        int         n;
        logic [4:0] e0;
        logic [4:0] e1;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int first_e;
        int pulses;

        // Press of set held 20 cycles, then release
        tbl[0]  = '{1'b1, 1'b0,  6, 5'b00000, 5'b00000};
        tbl[1]  = '{1'b1, 1'b0,  1, 5'b10101, 5'b10101};
        tbl[2]  = '{1'b1, 1'b0,  1, 5'b00001, 5'b00001};
        tbl[3]  = '{1'b1, 1'b0, 12, 5'b00001, 5'b00001};
        tbl[4]  = '{1'b0, 1'b0,  6, 5'b00001, 5'b00001};
        tbl[5]  = '{1'b0, 1'b0,  1, 5'b00000, 5'b00000};
        // Glitch on rst_btn shorter than DEB_CNT
        tbl[6]  = '{1'b0, 1'b1,  3, 5'b00000, 5'b00000};
        tbl[7]  = '{1'b0, 1'b0,  8, 5'b00000, 5'b00000};
        // Simultaneous press: conflict on p0, reset wins on p1
        tbl[8]  = '{1'b1, 1'b1,  6, 5'b00000, 5'b00000};
        tbl[9]  = '{1'b1, 1'b1,  1, 5'b00011, 5'b01101};
        tbl[10] = '{1'b1, 1'b1,  1, 5'b00001, 5'b00001};
        tbl[11] = '{1'b1, 1'b1,  3, 5'b00001, 5'b00001};
        tbl[12] = '{1'b0, 1'b0,  6, 5'b00001, 5'b00001};
        tbl[13] = '{1'b0, 1'b0,  1, 5'b00000, 5'b00000};

        rst = 1'b1; set_btn = 1'b0; rst_btn = 1'b0;
        model_reset();
        repeat (2) @(posedge Cp);
        #1;
        check("reset_state_p0", {27'd0, out0}, 32'd0);
        check("reset_state_p1", {27'd0, out1}, 32'd0);
        @(negedge Cp) rst = 1'b0;
        repeat (4) step();

        for (int i = 0; i < 14; i++) begin
            set_btn = tbl[i].set_b;
            rst_btn = tbl[i].rst_b;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d_p0", i), {27'd0, out0}, {27'd0, tbl[i].e0});
            check($sformatf("vec%0d_p1", i), {27'd0, out1}, {27'd0, tbl[i].e1});
        end

        // Bouncing set button, then stable high
        repeat (4) step();
        set_btn = 1'b1; step();
        set_btn = 1'b0; step();
        set_btn = 1'b1; step();
        set_btn = 1'b0; step();
        set_btn = 1'b1;
        first_e = 0; pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (S0) begin
                pulses++;
                if (first_e == 0) first_e = e;
            end
        end
        check("bounce_pulses", pulses, 32'd1);
        check("bounce_edge", first_e, 32'd7);
        set_btn = 1'b0;
        repeat (10) step();

        // Reset button pressed while busy is ignored, then works alone
        set_btn = 1'b1;
        repeat (8) step();
        rst_btn = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (R0 || R1) pulses++;
        end
        check("busy_ignore_r", pulses, 32'd0);
        set_btn = 1'b0; rst_btn = 1'b0;
        repeat (10) step();
        check("idle_after_release", {31'd0, b0}, 32'd0);
        rst_btn = 1'b1;
        first_e = 0; pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (R0) begin
                pulses++;
                if (first_e == 0) first_e = e;
            end
        end
        check("r_alone_pulses", pulses, 32'd1);
        check("r_alone_edge", first_e, 32'd7);
        rst_btn = 1'b0;
        repeat (10) step();

        // Asynchronous reset in HOLD with set held, then fresh press after release
        set_btn = 1'b1;
        repeat (8) step();
        check("hold_before_rst", {27'd0, out0}, 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_p0", {27'd0, out0}, 32'd0);
        check("async_rst_p1", {27'd0, out1}, 32'd0);
        repeat (3) step();
        @(negedge Cp) rst = 1'b0;
        first_e = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (S0 && first_e == 0) first_e = e;
        end
        check("rst_release_edge", first_e, 32'd7);
        set_btn = 1'b0;
        repeat (10) step();

        // Random presses and occasional asynchronous resets
        for (int it = 0; it < 150; it++) begin
            set_btn = 1'($urandom_range(0, 1));
            rst_btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1;
                check("rand_async_rst", {22'd0, out0, out1}, 32'd0);
                step();
                step();
                #2 rst = 1'b0;
            end
            repeat ($urandom_range(1, 14)) step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
